// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: arbiter FSM encoding and default SRAM geometry shared with the VGA and memory controllers
package sram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;
endpackage

// File: rtl/sram_arb_select.sv
// sram_arb_select: VGA-first priority with a starvation override that forces a CPU grant
module sram_arb_select #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic             cpu_elig,
    input  logic             vga_elig,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant,
    output logic             sel_vga
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
    always_comb begin
        grant   = cpu_elig | vga_elig;
        sel_vga = vga_elig & (~cpu_elig | (starve_cnt < LIM));
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises CPU and VGA requests onto one SRAM port; SRAM_ARB_STATS_EN adds grant counters
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int CPU_STARVE_LIMIT = 4,
    parameter int ADDR_W           = SRAM_ADDR_W,
    parameter int DATA_W           = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              vga_valid,
    input  logic              vga_we,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_ready,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_vga
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_vga_grants,
    output logic [15:0]       stat_cpu_forced
`endif
);
    localparam int CNT_W = $clog2(CPU_STARVE_LIMIT + 2);
    state_t state, state_n;
    logic [CNT_W-1:0] starve_cnt;
    logic cpu_elig, vga_elig, grant, sel_vga, take;

    always_comb begin
        cpu_elig = cpu_valid & ~cpu_ready;
        vga_elig = vga_valid & ~vga_ready;
        take     = (state == IDLE) & grant;
    end

    sram_arb_select #(
        .LIMIT(CPU_STARVE_LIMIT),
        .CNT_W(CNT_W)
    ) u_select (
        .cpu_elig  (cpu_elig),
        .vga_elig  (vga_elig),
        .starve_cnt(starve_cnt),
        .grant     (grant),
        .sel_vga   (sel_vga)
    );

    always_ff @(posedge clk) state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = (state == IDLE) ? (grant ? BUSY : IDLE) :
                  (state == BUSY) ? (mem_ready ? RESP : BUSY) : IDLE;
    end

    always_comb begin
        cpu_ready = (state == RESP) & ~grant_vga;
        vga_ready = (state == RESP) & grant_vga;
    end

    // a VGA grant only bumps the counter when it actually made the CPU wait
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            vga_rdata  <= '0;
            grant_vga  <= 1'b0;
            starve_cnt <= '0;
        end else if (take) begin
            mem_valid  <= 1'b1;
            mem_we     <= sel_vga ? vga_we : cpu_we;
            mem_addr   <= sel_vga ? vga_addr : cpu_addr;
            mem_wdata  <= sel_vga ? vga_wdata : cpu_wdata;
            grant_vga  <= sel_vga;
            starve_cnt <= ~sel_vga ? '0 : cpu_elig ? starve_cnt + 1'b1 : starve_cnt;
        end else if (state == BUSY && mem_ready) begin
            mem_valid <= 1'b0;
            if (grant_vga) vga_rdata <= mem_rdata;
            else cpu_rdata <= mem_rdata;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cpu_grants <= '0;
            stat_vga_grants <= '0;
            stat_cpu_forced <= '0;
        end else if (take && sel_vga) begin
            stat_vga_grants <= stat_vga_grants + 32'd1;
        end else if (take) begin
            stat_cpu_grants <= stat_cpu_grants + 32'd1;
            if (vga_elig) stat_cpu_forced <= stat_cpu_forced + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table plus reset, idle-ready and starvation sequences against a responding SRAM model
module tb_sram_arbiter;
    logic clk, reset;
    logic cpu_valid, cpu_we, vga_valid, vga_we, mem_valid, mem_we, mem_ready;
    logic cpu_ready, vga_ready, grant_vga;
    logic [18:0] cpu_addr, vga_addr, mem_addr;
    logic [15:0] cpu_wdata, vga_wdata, mem_wdata, cpu_rdata, vga_rdata, mem_rdata;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] stat_cpu_grants, stat_vga_grants;
    logic [15:0] stat_cpu_forced;
`endif

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .vga_valid(vga_valid), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
        .vga_rdata(vga_rdata), .vga_ready(vga_ready),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_vga(grant_vga)
`ifdef SRAM_ARB_STATS_EN
        , .stat_cpu_grants(stat_cpu_grants), .stat_vga_grants(stat_vga_grants),
        .stat_cpu_forced(stat_cpu_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv, cwe;
        logic [18:0] ca;
        logic [15:0] cwd;
        logic        vv, vwe;
        logic [18:0] va;
        logic [15:0] vwd;
        int          wt;
        logic [15:0] rd;
        logic        e_gv, e_we;
        logic [18:0] e_addr;
        logic [15:0] e_wd, e_crd, e_vrd;
        int          e_cyc;
    } vec_t;

    vec_t vt[5];
    int checks = 0, failures = 0;
    int cpu_done = 0, vga_done = 0, stable_err = 0, pulse_err = 0;
    int mem_wait = 0, wcnt = 0, ng = 0;
    logic resp_en, cpu_hold, vga_hold, mv_q, cr_q, vr_q;
    logic [15:0] resp_data;
    logic [35:0] pm;
    logic f_gv, f_we;
    logic [18:0] f_addr;
    logic [15:0] f_wd;
    logic gq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one cycle: observe outputs at the falling edge, then drive the SRAM model and requesters
    task automatic tick();
        @(negedge clk);
        if (mem_valid && mv_q && {mem_we, mem_addr, mem_wdata} != pm) stable_err++;
        if (mem_valid && !mv_q) begin
            gq.push_back(grant_vga);
            if (ng == 0) begin
                f_gv = grant_vga; f_we = mem_we; f_addr = mem_addr; f_wd = mem_wdata;
            end
            ng++;
        end
        mv_q = mem_valid;
        pm = {mem_we, mem_addr, mem_wdata};
        if ((cpu_ready && vga_ready) || (cpu_ready && cr_q) || (vga_ready && vr_q)) pulse_err++;
        cr_q = cpu_ready;
        vr_q = vga_ready;
        if (cpu_ready) begin cpu_done++; if (!cpu_hold) cpu_valid = 1'b0; end
        if (vga_ready) begin vga_done++; if (!vga_hold) vga_valid = 1'b0; end
        if (mem_ready) mem_ready = 1'b0;
        else if (resp_en && mem_valid) begin
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1; mem_rdata = resp_data; wcnt = 0;
            end else wcnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_valid = 1'b0; vga_valid = 1'b0; mem_ready = 1'b0; wcnt = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int c0, v0, lat;
    logic exp_pat[10];

    initial begin
        {cpu_valid, cpu_we, vga_valid, vga_we, mem_ready, cpu_hold, vga_hold, mv_q, cr_q, vr_q} = '0;
        cpu_addr = '0; vga_addr = '0; cpu_wdata = '0; vga_wdata = '0; mem_rdata = '0; resp_data = '0;
        pm = '0; resp_en = 1'b1;
        vt[0] = '{1'b1, 1'b0, 19'h00010, 16'h0000, 1'b0, 1'b0, 19'h0, 16'h0, 0, 16'hBEEF,
                  1'b0, 1'b0, 19'h00010, 16'h0000, 16'hBEEF, 16'h0000, 3};
        vt[1] = '{1'b1, 1'b0, 19'h00100, 16'h0000, 1'b1, 1'b1, 19'h7FFFF, 16'h1234, 0, 16'h5A5A,
                  1'b1, 1'b1, 19'h7FFFF, 16'h1234, 16'h5A5A, 16'h5A5A, 3};
        vt[2] = '{1'b0, 1'b0, 19'h0, 16'h0, 1'b1, 1'b0, 19'h00ABC, 16'h0000, 2, 16'hC0DE,
                  1'b1, 1'b0, 19'h00ABC, 16'h0000, 16'h5A5A, 16'hC0DE, 5};
        vt[3] = '{1'b1, 1'b1, 19'h40000, 16'hA5A5, 1'b0, 1'b0, 19'h0, 16'h0, 1, 16'h0F0F,
                  1'b0, 1'b1, 19'h40000, 16'hA5A5, 16'h0F0F, 16'hC0DE, 4};
        vt[4] = '{1'b1, 1'b0, 19'h12345, 16'h0000, 1'b0, 1'b0, 19'h0, 16'h0, 10, 16'h1111,
                  1'b0, 1'b0, 19'h12345, 16'h0000, 16'h1111, 16'hC0DE, 13};
        exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        do_reset();
        chk("reset_mem", {mem_valid, mem_we, mem_addr, mem_wdata, grant_vga}, 64'h0);
        chk("reset_req", {cpu_rdata, vga_rdata, cpu_ready, vga_ready}, 64'h0);

        for (int i = 0; i < 5; i++) begin
            mem_wait = vt[i].wt; resp_data = vt[i].rd; ng = 0; lat = 0;
            c0 = cpu_done; v0 = vga_done;
            cpu_valid = vt[i].cv; cpu_we = vt[i].cwe; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cwd;
            vga_valid = vt[i].vv; vga_we = vt[i].vwe; vga_addr = vt[i].va; vga_wdata = vt[i].vwd;
            for (int n = 1; n <= 200 && !(cpu_done - c0 == int'(vt[i].cv) && vga_done - v0 == int'(vt[i].vv)); n++) begin
                tick();
                if (lat == 0 && cpu_done + vga_done != c0 + v0) lat = n + 1;
            end
            chk($sformatf("v%0d_cpu_done", i), cpu_done - c0, vt[i].cv);
            chk($sformatf("v%0d_vga_done", i), vga_done - v0, vt[i].vv);
            chk($sformatf("v%0d_grants", i), ng, int'(vt[i].cv) + int'(vt[i].vv));
            chk($sformatf("v%0d_first_owner", i), f_gv, vt[i].e_gv);
            chk($sformatf("v%0d_mem_we", i), f_we, vt[i].e_we);
            chk($sformatf("v%0d_mem_addr", i), f_addr, vt[i].e_addr);
            chk($sformatf("v%0d_mem_wdata", i), f_wd, vt[i].e_wd);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vt[i].e_crd);
            chk($sformatf("v%0d_vga_rdata", i), vga_rdata, vt[i].e_vrd);
            chk($sformatf("v%0d_cycles", i), lat, vt[i].e_cyc);
            tick();
        end

        c0 = cpu_done + vga_done;
        mem_rdata = 16'hDEAD; mem_ready = 1'b1;
        repeat (4) tick();
        chk("idle_mem_ready_rdata", {cpu_rdata, vga_rdata}, {16'h1111, 16'hC0DE});
        chk("idle_mem_ready_done", cpu_done + vga_done - c0, 0);

        resp_en = 1'b0;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00777;
        for (int n = 0; n < 20 && !mem_valid; n++) tick();
        repeat (2) tick();
        chk("busy_before_reset", mem_valid, 1'b1);
        c0 = cpu_done + vga_done;
        reset = 1'b1; cpu_valid = 1'b0;
        tick();
        chk("midreset_mem", {mem_valid, mem_we, mem_addr, mem_wdata, grant_vga}, 64'h0);
        chk("midreset_req", {cpu_rdata, vga_rdata, cpu_ready, vga_ready}, 64'h0);
        reset = 1'b0; resp_en = 1'b1; mem_wait = 0;
        repeat (4) tick();
        chk("midreset_no_ready", cpu_done + vga_done - c0, 0);
        v0 = vga_done; resp_data = 16'h7777;
        vga_valid = 1'b1; vga_we = 1'b0; vga_addr = 19'h00055;
        for (int n = 0; n < 50 && vga_done == v0; n++) tick();
        chk("after_reset_vga_rdata", vga_rdata, 16'h7777);
        chk("after_reset_cpu_rdata", cpu_rdata, 16'h0000);
        tick();

        do_reset();
        gq.delete(); resp_data = 16'h2222; mem_wait = 0;
        cpu_hold = 1'b1; vga_hold = 1'b1;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00AAA;
        vga_valid = 1'b1; vga_we = 1'b0; vga_addr = 19'h00BBB;
        for (int n = 0; n < 400 && gq.size() < 10; n++) tick();
        chk("starve_count", gq.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("starve_g%0d", i), gq.size() > i ? gq[i] : 1'bx, exp_pat[i]);
`ifdef SRAM_ARB_STATS_EN
        chk("stat_vga_grants", stat_vga_grants, 8);
        chk("stat_cpu_grants", stat_cpu_grants, 2);
        chk("stat_cpu_forced", stat_cpu_forced, 2);
`endif
        c0 = cpu_done;
        cpu_hold = 1'b0; vga_hold = 1'b0; cpu_valid = 1'b0; vga_valid = 1'b0;
        for (int n = 0; n < 50 && cpu_done == c0; n++) tick();
        chk("dropped_valid_completes", cpu_done - c0, 1);
        chk("dropped_valid_rdata", cpu_rdata, 16'h2222);
        repeat (4) tick();

        chk("mem_stable", stable_err, 0);
        chk("ready_pulse", pulse_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
